vc_arbiter_demux: RTL
=====================

# vc_arbiter_demux

Downstream stage of the initial-logic block. It drains the VC0 and VC1 FIFOs with strict priority to VC0, and routes each drained word to one of two destination FIFOs (D0/D1) by a destination bit in the word. It honours back-pressure from the destinations, keeps a word count per destination, and reports idle/active status to the top-level control.

## Interface
Parameters:
- data_width, 6, word width
- count_width, 5, width of per-destination push counters

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- empty_fifo_VC0  input  1  VC0 FIFO empty
- empty_fifo_VC1  input  1  VC1 FIFO empty
- data_in_VC0  input  data_width  VC0 FIFO read data, valid the cycle after a pop
- data_in_VC1  input  data_width  VC1 FIFO read data, valid the cycle after a pop
- pause_d0  input  1  D0 FIFO almost-full
- pause_d1  input  1  D1 FIFO almost-full
- pop_VC0_fifo  output  1  read strobe to VC0 FIFO (combinational)
- pop_VC1_fifo  output  1  read strobe to VC1 FIFO (combinational)
- push_d0  output  1  write strobe to D0 FIFO (registered)
- push_d1  output  1  write strobe to D1 FIFO (registered)
- data_out_d0  output  data_width  D0 write data (registered)
- data_out_d1  output  data_width  D1 write data (registered)
- idle_out  output  1  high in IDLE (registered)
- active_out  output  1  high in ACTIVE (registered)
- count_d0  output  count_width  pushes to D0 since reset
- count_d1  output  count_width  pushes to D1 since reset

## Operation
- FSM states:
  - IDLE: go to ACTIVE when !empty_fifo_VC0 or !empty_fifo_VC1.
  - ACTIVE: go to IDLE when both VC FIFOs are empty and no word is in flight (pipeline valid bits both 0).
- Stall condition: stall = pause_d0 | pause_d1. Any destination pause stops both VCs, so there is no reordering and no head-of-line bypass.
- Pop decode, combinational:
  - pop_VC0_fifo = ACTIVE & !stall & !empty_fifo_VC0
  - pop_VC1_fifo = ACTIVE & !stall & empty_fifo_VC0 & !empty_fifo_VC1
  - The two pops are never high together. Strict priority: VC1 is starved while VC0 is non-empty.
- Stage 1 registers: valid1 <= pop_VC0|pop_VC1; src1 <= pop_VC1 (0 = VC0, 1 = VC1).
- Stage 2 registers:
  - When valid1, word = src1 ? data_in_VC1 : data_in_VC0.
  - Destination bit = word[data_width-2] (bit 4 at default): 0 -> D0, 1 -> D1.
  - The selected data_out_dX is loaded with word and push_dX=1 for one cycle.
  - The other data_out holds its value and its push is 0.
- Counters:
  - count_dX increments by 1 on each cycle push_dX is high.
  - Wraps modulo 2^count_width (31 -> 0).
- Reset (reset=0, asynchronous, any time):
  - State -> IDLE; idle_out=1, active_out=0.
  - valid1, src1, push_d0, push_d1 = 0.
  - data_out_d0/d1 = 0; count_d0/d1 = 0.
  - pops forced to 0 because the state is IDLE.
  - Words in flight at reset are discarded.

## Timing
- Pop in cycle N -> FIFO data valid in N+1 -> push_dX and data_out_dX valid in cycle N+2. Latency is 2 cycles.
- Throughput is 1 word/cycle while not stalled.
- First pop occurs the cycle after leaving IDLE, i.e. 1 cycle after the first non-empty is seen.
- A pause asserted in cycle N blocks the pop in cycle N. Up to 2 words already in flight still complete. Destination almost-full thresholds must leave at least 2 entries of headroom.
- Pause deasserted in cycle N: pop resumes in cycle N (combinational).
- The ACTIVE -> IDLE exit waits for the last push; idle_out rises the cycle after the last push.

## Test plan
- Reset check: hold reset=0 with random inputs -> all outputs 0 except idle_out=1; no pop.
- Single word: VC0 holds 6'b010101 (bit4=1) -> pop_VC0 in cycle N, push_d1=1 with data_out_d1=6'b010101 in N+2, count_d1=1, then return to IDLE.
- Priority: VC0 holds 3 words, VC1 holds 2 -> pops are VC0, VC0, VC0, VC1, VC1 on consecutive cycles; pushes match that order 2 cycles later.
- Back-pressure: pause_d0=1 mid-burst -> pops stop that cycle, at most 2 trailing pushes, no loss. Release -> remaining words arrive in order.
- Wrap: 33 words routed to D0 -> count_d0=1 at the end.
- Mid-operation reset: reset=0 while valid1=1 -> no push follows; counters 0; normal operation after release.

Source files
------------

// File: rtl/vc_arbiter_demux.sv
// vc_arbiter_demux: drains the VC0/VC1 FIFOs with strict priority to VC0 and
// routes every drained word to destination FIFO D0 or D1. The destination is
// chosen by bit data_width-2 of the word. Any destination pause stalls both
// VCs. Pops are combinational; pushes, data, status and counters are registered.
module vc_arbiter_demux #(
    parameter int data_width  = 6,
    parameter int count_width = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   empty_fifo_VC0,
    input  logic                   empty_fifo_VC1,
    input  logic [data_width-1:0]  data_in_VC0,
    input  logic [data_width-1:0]  data_in_VC1,
    input  logic                   pause_d0,
    input  logic                   pause_d1,
    output logic                   pop_VC0_fifo,
    output logic                   pop_VC1_fifo,
    output logic                   push_d0,
    output logic                   push_d1,
    output logic [data_width-1:0]  data_out_d0,
    output logic [data_width-1:0]  data_out_d1,
    output logic                   idle_out,
    output logic                   active_out,
    output logic [count_width-1:0] count_d0,
    output logic [count_width-1:0] count_d1
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   stall;
    logic                   pop_vc0, pop_vc1;
    logic                   valid1_q, valid1_d;
    logic                   src1_q, src1_d;
    logic [data_width-1:0]  word;
    logic                   push_d0_q, push_d0_d;
    logic                   push_d1_q, push_d1_d;
    logic [data_width-1:0]  data_out_d0_q, data_out_d0_d;
    logic [data_width-1:0]  data_out_d1_q, data_out_d1_d;
    logic                   idle_q, idle_d;
    logic                   active_q, active_d;
    logic [count_width-1:0] count_d0_q, count_d0_d;
    logic [count_width-1:0] count_d1_q, count_d1_d;

    // Next state and pop decode: VC0 wins whenever it is non-empty.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d = state_q;
        stall   = pause_d0 | pause_d1;
        pop_vc0 = 1'b0;
        pop_vc1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_fifo_VC0 || !empty_fifo_VC1) state_d = ACTIVE;
            end
            ACTIVE: begin
                pop_vc0 = !stall && !empty_fifo_VC0;
                pop_vc1 = !stall && empty_fifo_VC0 && !empty_fifo_VC1;
                // The word in stage 2 is pushed this cycle. Only stage 1 must be empty,
                // so idle follows the last push by one cycle.
                if (empty_fifo_VC0 && empty_fifo_VC1 && !valid1_q) state_d = IDLE;
            end
        endcase
    end

    // Pipeline: stage 1 remembers the popped source. Stage 2 routes the FIFO data and counts pushes.
    always_comb begin
        valid1_d      = pop_vc0 | pop_vc1;
        src1_d        = pop_vc1;
        word          = src1_q ? data_in_VC1 : data_in_VC0;
        push_d0_d     = 1'b0;
        push_d1_d     = 1'b0;
        data_out_d0_d = data_out_d0_q;
        data_out_d1_d = data_out_d1_q;
        if (valid1_q) begin
            if (word[data_width-2]) begin
                push_d1_d     = 1'b1;
                data_out_d1_d = word;
            end else begin
                push_d0_d     = 1'b1;
                data_out_d0_d = word;
            end
        end
        count_d0_d = count_d0_q + {{(count_width-1){1'b0}}, push_d0_q};
        count_d1_d = count_d1_q + {{(count_width-1){1'b0}}, push_d1_q};
        idle_d     = (state_d == IDLE);
        active_d   = (state_d == ACTIVE);
    end

    // All state registers. Reset discards any words that are in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            valid1_q      <= 1'b0;
            src1_q        <= 1'b0;
            push_d0_q     <= 1'b0;
            push_d1_q     <= 1'b0;
            data_out_d0_q <= '0;
            data_out_d1_q <= '0;
            idle_q        <= 1'b1;
            active_q      <= 1'b0;
            count_d0_q    <= '0;
            count_d1_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the value it
            // had before this edge, so the order of these lines does not matter.
            state_q       <= state_d;
            valid1_q      <= valid1_d;
            src1_q        <= src1_d;
            push_d0_q     <= push_d0_d;
            push_d1_q     <= push_d1_d;
            data_out_d0_q <= data_out_d0_d;
            data_out_d1_q <= data_out_d1_d;
            idle_q        <= idle_d;
            active_q      <= active_d;
            count_d0_q    <= count_d0_d;
            count_d1_q    <= count_d1_d;
        end
    end

    assign pop_VC0_fifo = pop_vc0;
    assign pop_VC1_fifo = pop_vc1;
    assign push_d0      = push_d0_q;
    assign push_d1      = push_d1_q;
    assign data_out_d0  = data_out_d0_q;
    assign data_out_d1  = data_out_d1_q;
    assign idle_out     = idle_q;
    assign active_out   = active_q;
    assign count_d0     = count_d0_q;
    assign count_d1     = count_d1_q;

endmodule
